byte_registers: RTL and testbench
=================================

# byte_registers

- Byte-wide register file with a simple edge-triggered host protocol.
- Writes take two phases on `data_in`:
  - Address, latched when `write` rises.
  - Data, latched when `write` falls.
- A read takes a `read` pulse with the address on `data_in`. It returns the addressed byte on `data_out`, qualified by a one-cycle `valid` strobe.
- Sits behind a byte-serial host interface (UART/SPI decoder) as the design's control/status store.

## Interface
- `N_REGS`, default 32, number of implemented registers (1..256).
- `RESET_VAL`, default 8'h00, value loaded into every register on reset.
- `clk` input 1: single system clock, rising-edge active.
- `nRst` input 1: reset, asynchronous and active-low.
- `data_in` input 8: address (read, or write phase 1) or write data (write phase 2).
- `read` input 1: read request; acts on its rising edge.
- `write` input 1: write request. Rising edge latches the address; falling edge commits the data.
- `data_out` output 8: read data; holds its value between reads.
- `valid` output 1: one-cycle strobe marking new `data_out`.

## Operation
- All inputs are synchronous to `clk`; no internal synchronisers.
- `read_q` and `write_q` are registered copies of `read` and `write`. Edges are detected by comparing each input with its registered copy.
- Write:
  - At a posedge with `write`=1 and `write_q`=0: `addr_q <= data_in`.
  - At a posedge with `write`=0 and `write_q`=1: if `addr_q < N_REGS`, `regs[addr_q] <= data_in`.
  - Otherwise the data is discarded.
- Read:
  - At a posedge with `read`=1, `read_q`=0, `write`=0 and `write_q`=0: `data_out <= regs[data_in]`, or 8'h00 if `data_in >= N_REGS`, and `valid <= 1`.
  - `valid` returns to 0 at the next posedge.
- Priority: write has priority. A read rising edge while `write` or `write_q` is high is ignored and is not retried later.
- Holding `read` high produces exactly one access. Holding `write` high for any length produces exactly one write, at the falling edge.
- Simultaneous `read`/`write` rise: only the write runs; its address is `data_in` at the rise edge.
- No read-during-write bypass: a read returns the value stored before any commit at the same posedge.

## Timing
- Reset values (asynchronous while `nRst`=0):
  - All `regs` = `RESET_VAL`.
  - `data_out` = 8'h00, `valid` = 0.
  - `addr_q` = 0, `read_q` = `write_q` = 0.
- A reset during a write aborts it: no commit occurs. A `write` already high when reset releases does not register a rising edge until it falls and rises again.
- Read latency: `data_out`/`valid` update at the same posedge that samples the `read` rise. They are visible one cycle after `read` is first sampled high.
- Write commit: the register updates at the posedge that samples `write` low; a read started later sees the new value.
- Minimum legal pulse: one cycle high and one cycle low for each of `read` and `write`.

## Configuration
- `BYTE_REGISTERS_WRITE_ACK_EN`:
  - Defined: a committed write also pulses `valid` for one cycle and drives `data_out` with the written byte. Out-of-range writes produce no acknowledge.
  - Undefined: `valid` and `data_out` are driven only by reads.

## Structure
- Shared package `byte_registers_pkg` holds:
  - The data/address width constant (8).
  - The default `N_REGS` and `RESET_VAL`.
  - The out-of-range read value (8'h00).
- One sub-module, `edge_detect`, registers one input and outputs `rise` and `fall`. It is instantiated once for `read` and once for `write`, each with async active-low reset.

## Test plan
- Reset: assert `nRst`=0 mid-stream -> `data_out`=8'h00, `valid`=0, and reads of addresses 0..31 return 8'h00 afterwards.
- Write/read: for i=0..19, write `addr`=i with `data`=8'hF0-i, then read back 0..19 -> `regs[0]`=8'hF0, `regs[1]`=8'hEF, `regs[19]`=8'hDD. Each read gives exactly one `valid` cycle.
- Out of range: read addresses 32..255 -> `data_out`=8'h00 with `valid`=1. Writing address 8'h40 leaves all registers unchanged.
- Simultaneous requests: hold `read`=`write`=1 for 20 cycles with `data_in` at 0 on the rise and 19 on the fall -> `regs[0]`=19, no `valid` (macro off).
- Held read: `read` held high for 10 cycles -> exactly one `valid` pulse, with `data_out` equal to the register at the address sampled on the rise.
- Reset abort: write address 5, then reset while `write`=1 -> `regs[5]` stays `RESET_VAL` after release.

Source files
------------

// File: rtl/byte_registers_pkg.sv
// Shared constants for the byte_registers block: data/address width,
// default geometry and reset value, and the value returned for unmapped reads.
package byte_registers_pkg;
    localparam int             DATA_W            = 8;
    localparam int             DEFAULT_N_REGS    = 32;
    localparam logic [DATA_W-1:0] DEFAULT_RESET_VAL = 8'h00;
    localparam logic [DATA_W-1:0] OOR_READ_VAL      = 8'h00;
endpackage

// File: rtl/byte_registers_edge_detect.sv
// edge_detect: registers one synchronous input and flags its rising and
// falling edges by comparing the live input with the registered copy.
module edge_detect (
    input  logic clk,
    input  logic nRst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    // One-cycle delayed copy of the input
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) q <= 1'b0;
        else       q <= d;
    end

    assign rise = d & ~q;
    assign fall = ~d & q;
endmodule

// File: rtl/byte_registers.sv
// byte_registers: byte-wide register file behind an edge-triggered host
// protocol. write rise latches the address, write fall commits data_in;
// a read rise returns the addressed byte with a one-cycle valid strobe.
// Optional feature macro: BYTE_REGISTERS_WRITE_ACK_EN -- committed in-range
// writes also strobe valid and echo the written byte on data_out.
module byte_registers
    import byte_registers_pkg::*;
#(
    parameter int                N_REGS    = DEFAULT_N_REGS,
    parameter logic [DATA_W-1:0] RESET_VAL = DEFAULT_RESET_VAL
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] data_out,
    output logic              valid
);
    logic                           read_q, read_rise, read_fall_unused;
    logic                           write_q, w_rise, w_fall;
    logic                           wr_armed, wr_rise, wr_fall, rd_go;
    logic [DATA_W-1:0]              addr_q, rd_val;
    logic [N_REGS-1:0][DATA_W-1:0]  regs;

    edge_detect u_read_edge (
        .clk (clk), .nRst(nRst), .d(read),
        .q   (read_q), .rise(read_rise), .fall(read_fall_unused)
    );

    edge_detect u_write_edge (
        .clk (clk), .nRst(nRst), .d(write),
        .q   (write_q), .rise(w_rise), .fall(w_fall)
    );

    // A write held high across reset release must not count as a new
    // transaction: edges are honoured only once write has been seen low.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)       wr_armed <= 1'b0;
        else if (!write) wr_armed <= 1'b1;
    end

    assign wr_rise = w_rise & wr_armed;
    assign wr_fall = w_fall & wr_armed;
    // Writes win: a read rise during any part of a write is dropped.
    assign rd_go   = read_rise & ~write & ~write_q;

    // Address phase of a write
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)        addr_q <= '0;
        else if (wr_rise) addr_q <= data_in;
    end

    // Data phase: commit to the matching register; unmapped addresses match none
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= RESET_VAL;
        end else if (wr_fall) begin
            for (int i = 0; i < N_REGS; i++)
                if (addr_q == DATA_W'(i)) regs[i] <= data_in;
        end
    end

    // Read mux on the live address; pre-commit contents, so no bypass
    always_comb begin
        rd_val = OOR_READ_VAL;
        for (int i = 0; i < N_REGS; i++)
            if (data_in == DATA_W'(i)) rd_val = regs[i];
    end

`ifdef BYTE_REGISTERS_WRITE_ACK_EN
    logic wr_ack;
    assign wr_ack = wr_fall & ({1'b0, addr_q} < (DATA_W+1)'(N_REGS));

    // Read data / valid strobe, plus write acknowledge echo
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rd_go) begin
                data_out <= rd_val;
                valid    <= 1'b1;
            end else if (wr_ack) begin
                data_out <= data_in;
                valid    <= 1'b1;
            end
        end
    end
`else
    // Read data / valid strobe; data_out holds between reads
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rd_go) begin
                data_out <= rd_val;
                valid    <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_byte_registers.sv
// Directed table-driven bench for byte_registers plus hand-written
// sequences for reset, simultaneous requests, held read and reset abort.
module tb_byte_registers;
    logic       clk = 1'b0;
    logic       nRst;
    logic [7:0] data_in;
    logic       read, write;
    logic [7:0] data_out;
    logic       valid;

    int n_vec  = 0;
    int n_fail = 0;

    byte_registers dut (
        .clk(clk), .nRst(nRst), .data_in(data_in), .read(read),
        .write(write), .data_out(data_out), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        data_in = a; write = 1'b1;
        tick();
        data_in = d; write = 1'b0;
        tick();
`ifdef BYTE_REGISTERS_WRITE_ACK_EN
        if (a < 8'd32) begin
            chk($sformatf("wr_ack_valid[%0d]", a), {7'd0, valid}, 8'd1);
            chk($sformatf("wr_ack_data[%0d]", a), data_out, d);
        end else
            chk($sformatf("wr_oor_noack[%0d]", a), {7'd0, valid}, 8'd0);
`else
        chk($sformatf("wr_novalid[%0d]", a), {7'd0, valid}, 8'd0);
`endif
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
        data_in = a; read = 1'b1;
        tick();
        chk($sformatf("rd_valid[%0d]", a), {7'd0, valid}, 8'd1);
        chk($sformatf("rd_data[%0d]", a), data_out, exp);
        read = 1'b0; data_in = 8'hXX ^ 8'hXX;
        tick();
        chk($sformatf("rd_valid_drop[%0d]", a), {7'd0, valid}, 8'd0);
    endtask

    initial begin
        int nv;
        logic [7:0] cap;

        nRst = 1'b0; data_in = 8'h00; read = 1'b0; write = 1'b0;
        tick(); tick();
        chk("reset_data_out", data_out, 8'h00);
        chk("reset_valid", {7'd0, valid}, 8'd0);
        nRst = 1'b1;
        tick(); tick();

        // Build vector table
        for (int i = 0; i < 20; i++) tbl.push_back('{1'b1, 8'(i), 8'(8'hF0 - i)});
        for (int i = 0; i < 20; i++) tbl.push_back('{1'b0, 8'(i), 8'(8'hF0 - i)});
        for (int i = 20; i < 32; i++) tbl.push_back('{1'b0, 8'(i), 8'h00});
        tbl.push_back('{1'b0, 8'd32,  8'h00});
        tbl.push_back('{1'b0, 8'd100, 8'h00});
        tbl.push_back('{1'b0, 8'd255, 8'h00});
        tbl.push_back('{1'b1, 8'h40,  8'hAA});
        for (int i = 0; i < 32; i++)
            tbl.push_back('{1'b0, 8'(i), (i < 20) ? 8'(8'hF0 - i) : 8'h00});

        foreach (tbl[k]) begin
            if (tbl[k].is_wr) do_write(tbl[k].addr, tbl[k].data);
            else              do_read(tbl[k].addr, tbl[k].data);
        end

        // Simultaneous read/write rise held for 20 cycles
        nv = 0;
        data_in = 8'd0; read = 1'b1; write = 1'b1;
        tick();
        if (valid) nv++;
        data_in = 8'd19;
        for (int c = 1; c < 20; c++) begin
            tick();
            if (valid) nv++;
        end
        read = 1'b0; write = 1'b0;
        tick();
        if (valid) nv++;
        tick();
`ifdef BYTE_REGISTERS_WRITE_ACK_EN
        chk("simul_valid_count", 8'(nv), 8'd1);
`else
        chk("simul_valid_count", 8'(nv), 8'd0);
`endif
        do_read(8'd0, 8'd19);

        // Held read: one pulse, data for address sampled at rise
        nv = 0; cap = 8'h00;
        data_in = 8'd1; read = 1'b1;
        tick();
        if (valid) begin nv++; cap = data_out; end
        data_in = 8'd3;
        for (int c = 1; c < 10; c++) begin
            tick();
            if (valid) begin nv++; cap = data_out; end
        end
        read = 1'b0;
        tick();
        if (valid) nv++;
        chk("held_read_pulses", 8'(nv), 8'd1);
        chk("held_read_data", cap, 8'hEF);

        // Mid-stream asynchronous reset
        #2 nRst = 1'b0;
        #1;
        chk("midreset_data_out", data_out, 8'h00);
        chk("midreset_valid", {7'd0, valid}, 8'd0);
        tick();
        nRst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 32; i++) do_read(8'(i), 8'h00);

        // Reset during a write aborts it; write held across release is ignored
        data_in = 8'd5; write = 1'b1;
        tick();
        #2 nRst = 1'b0;
        tick();
        nRst = 1'b1;
        tick(); tick();
        data_in = 8'h77; write = 1'b0;
        tick(); tick();
        do_read(8'd5, 8'h00);
        do_read(8'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
